// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Generates the fetch PC and issues
// in-order requests to a variable-latency instruction memory. Returned
// instructions are buffered in a DEPTH-entry queue that feeds decode through a
// valid/ready handshake. A redirect flushes the queue and discards any
// responses that are still in flight.
module fetch_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] INC      = ADDR_W'(2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_pred_taken,
  input  logic              inst_ready
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  // Back-to-back redirects can stack stale responses beyond one queue's
  // worth, so the drop counter gets headroom and saturates.
  localparam int DROP_W = PTR_W + 2;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] ent_pc   [DEPTH];
  logic              ent_pred [DEPTH];
  logic [INST_W-1:0] ent_inst [DEPTH];
  logic [DEPTH-1:0]  ent_filled;

  logic [PTR_W-1:0]  alloc_ptr, fill_ptr, rd_ptr;
  logic [CNT_W-1:0]  alloc_cnt;   // entries allocated and not yet dequeued
  logic [CNT_W-1:0]  pend_cnt;    // allocated entries still waiting for data
  logic [DROP_W-1:0] drop_cnt;    // stale responses still to be discarded

  logic              issue, deq, resp_fill, resp_drop;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_next;

  // Request is held low during reset so no fetch leaks out before release.
  assign mem_req         = rst_n & ~redirect & (alloc_cnt < CNT_W'(DEPTH));
  assign mem_addr        = fetch_pc;
  assign issue           = mem_req & mem_ready;

  assign inst_valid      = ~redirect & ent_filled[rd_ptr];
  assign deq             = inst_valid & inst_ready;
  assign inst            = ent_inst[rd_ptr];
  assign inst_pc         = ent_pc[rd_ptr];
  assign inst_pred_taken = ent_pred[rd_ptr];

  assign resp_fill = ~redirect & mem_rvalid & (drop_cnt == '0) & (pend_cnt != '0);
  assign resp_drop = ~redirect & mem_rvalid & (drop_cnt != '0);

  // Drop count after a redirect: everything unfilled becomes stale, minus the
  // response arriving in the redirect cycle itself; saturates at both ends.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    drop_next = drop_cnt;
    drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(pend_cnt);
    if (mem_rvalid && drop_sum != '0) drop_sum = drop_sum - (DROP_W+1)'(1);
    if (drop_sum[DROP_W]) drop_next = '1;
    else                  drop_next = drop_sum[DROP_W-1:0];
  end

  // Fetch PC, pointers and occupancy counters.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_next;
    end else begin
      if (issue) begin
        fetch_pc  <= pred_taken ? pred_target : fetch_pc + INC;
        alloc_ptr <= alloc_ptr + PTR_W'(1);
      end
      if (resp_fill) fill_ptr <= fill_ptr + PTR_W'(1);
      if (resp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
      if (deq)       rd_ptr   <= rd_ptr + PTR_W'(1);

      case ({issue, deq})
        2'b10:   alloc_cnt <= alloc_cnt + CNT_W'(1);
        2'b01:   alloc_cnt <= alloc_cnt - CNT_W'(1);
        default: alloc_cnt <= alloc_cnt;
      endcase

      case ({issue, resp_fill})
        2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
        2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  // Queue entries: allocate on issue, fill on response, release on dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the entry storage is reset because the head fields drive outputs that must read zero in reset.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_pred[i] <= 1'b0;
        ent_inst[i] <= '0;
      end
      ent_filled <= '0;
    end else if (redirect) begin
      ent_filled <= '0;
    end else begin
      if (issue) begin
        ent_pc[alloc_ptr]     <= fetch_pc;
        ent_pred[alloc_ptr]   <= pred_taken;
        ent_filled[alloc_ptr] <= 1'b0;
      end
      if (resp_fill) begin
        ent_inst[fill_ptr]   <= mem_rdata;
        ent_filled[fill_ptr] <= 1'b1;
      end
      if (deq) ent_filled[rd_ptr] <= 1'b0;
    end
  end

endmodule
